// File: rtl/instr_loader_if.sv
// ---------------------------------------------------------------------------
// instr_loader_if
// Groups the program-load handshake, the byte stream and the instruction
// memory write port of the instruction loader into one bundle.
//   master : the side that requests loads and supplies program bytes
//   slave  : the loader itself
// Signals:
//   load_start / load_len        load request and its length in words
//   in_data / in_valid / in_ready byte stream handshake
//   instr_in / instr_wr_addr /
//   instr_wr_en                  instruction memory write port (byte address)
//   cpu_reset / busy / done / err status towards the core and the host
// ---------------------------------------------------------------------------
interface instr_loader_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
);
  localparam int LOGSIZE = $clog2(SIZE);

  logic               load_start;
  logic [LOGSIZE:0]   load_len;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   instr_in;
  logic [LOGSIZE+1:0] instr_wr_addr;
  logic               instr_wr_en;
  logic               cpu_reset;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output load_start, load_len, in_data, in_valid,
    input  in_ready, instr_in, instr_wr_addr, instr_wr_en,
           cpu_reset, busy, done, err
  );

  modport slave (
    input  load_start, load_len, in_data, in_valid,
    output in_ready, instr_in, instr_wr_addr, instr_wr_en,
           cpu_reset, busy, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Loads a program into instruction memory from an 8-bit byte stream.
// Bytes are packed little-endian into 32-bit words; each completed word is
// written one cycle after its last byte arrives, at byte address 4*index.
// The processor core is held in reset until the whole program has been
// written.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : instr_loader_if slave modport (handshake, byte stream, memory
//           write port, status)
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
) (
  input logic           clk,
  input logic           reset,
  instr_loader_if.slave bus
);
  localparam int LOGSIZE = $clog2(SIZE);
  localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [LOGSIZE:0]   len_q;
  logic [LOGSIZE:0]   word_cnt_q;
  logic [1:0]         byte_cnt_q;
  logic               in_ready_q;
  logic               wr_en_q;
  logic               cpu_reset_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [WIDTH-1:0]   instr_q;
  logic [LOGSIZE+1:0] addr_q;

  logic               xfer;
  logic               len_ok;
  logic [23:0]        partial;

  assign xfer   = bus.in_valid && in_ready_q;
  assign len_ok = (bus.load_len != '0) && (bus.load_len <= SIZE_W);

  // Byte lanes 0..2 of the word under assembly. Lane 3 never needs storage:
  // it is taken straight from the stream when the word is written.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_q <= '0;
      end else if (xfer && (byte_cnt_q == 2'(gi))) begin
        lane_q <= bus.in_data;
      end
    end
  end

  assign partial = {g_lane[2].lane_q, g_lane[1].lane_q, g_lane[0].lane_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.load_start) begin
            if (len_ok) begin
              state_q     <= LOAD;
              len_q       <= bus.load_len;
              word_cnt_q  <= '0;
              byte_cnt_q  <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              cpu_reset_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              instr_q    <= {bus.in_data, partial};
              addr_q     <= {word_cnt_q[LOGSIZE-1:0], 2'b00};
              wr_en_q    <= 1'b1;
              word_cnt_q <= word_cnt_q + (LOGSIZE+1)'(1);
            end
          end
          // The final strobe is on the write port this cycle; leave LOAD now
          // so the core comes out of reset on the cycle right after it.
          // Any byte offered during this last cycle is dropped.
          if (wr_en_q && (word_cnt_q == len_q)) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.instr_in      = instr_q;
  assign bus.instr_wr_addr = addr_q;
  assign bus.instr_wr_en   = wr_en_q;
  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule
